// File: rtl/bank_io_pkg.sv
// Shared constants for the board I/O bank blocks: bank width and debounce depths.
package bank_io_pkg;
    localparam int BANK_W         = 8;
    localparam int DEBOUNCE_SIM   = 4;
    localparam int DEBOUNCE_BOARD = 50000;
endpackage

// File: rtl/debounce_bit.sv
// Synchronises and debounces one pin, with registered rise/fall pulses.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES cycles from a clean pin step to stable.
// Backpressure: none; free-running every cycle.
module debounce_bit #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic stable,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic                   s;
    logic                   toggle;

    assign s      = sync_q[SYNC_STAGES-1];
    assign toggle = (s != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    // Any sample matching the current level restarts the persistence count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            rise <= toggle && s;
            fall <= toggle && !s;
            if (s == stable || toggle) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (toggle) begin
                stable <= s;
            end
        end
    end
endmodule

// File: rtl/bank_debounce_rx.sv
// Debounced pin bank with edge pulses and a merged change-event valid/ready port.
// Latency: event posted one cycle after the rise/fall pulse.
// Backpressure: a stalled event absorbs later changes by merging; overlap flags overflow.
module bank_debounce_rx
    import bank_io_pkg::*;
#(
    parameter int WIDTH           = BANK_W,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_BOARD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] bank_in,
    output logic [WIDTH-1:0] stable,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             evt_valid,
    output logic [WIDTH-1:0] evt_data,
    output logic [WIDTH-1:0] evt_changed,
    input  logic             evt_ready,
    output logic             overflow,
    input  logic             ovf_clr
);
    logic [WIDTH-1:0] chg;
    logic             accept;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (bank_in[g]),
            .stable(stable[g]),
            .rise  (rise[g]),
            .fall  (fall[g])
        );
    end

    assign chg    = rise | fall;
    assign accept = evt_valid && evt_ready;

    // A change arriving on the accept cycle starts a fresh event rather than merging.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid   <= 1'b0;
            evt_data    <= '0;
            evt_changed <= '0;
        end else if (chg != '0) begin
            evt_valid   <= 1'b1;
            evt_data    <= stable;
            evt_changed <= (!evt_valid || accept) ? chg : (evt_changed | chg);
        end else if (accept) begin
            evt_valid   <= 1'b0;
            evt_changed <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (evt_valid && !accept && ((evt_changed & chg) != '0)) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end
endmodule
